// File: rtl/ringosc_freq_meter.sv
// Ring oscillator frequency meter: counts synchronised rising edges of osc_in over a
// programmable window of clk cycles and hands the count to the readout with valid/ready.
module ringosc_freq_meter #(
  parameter int CNT_W       = 24,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_in,
  input  logic              start,
  input  logic              continuous,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic              overflow,
  output logic              result_valid,
  input  logic              result_ready
);

  typedef enum logic {IDLE, GATE} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   rise;
  logic [GATE_W-1:0]      gate_cnt;
  logic [GATE_W-1:0]      gate_load;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   sat_flag;
  logic                   flag_next;
  logic                   load_window;
  logic                   window_end;

  // The previous-sample flop runs every cycle, so a window never sees a stale edge on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], osc_in};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign gate_load = (gate_cycles == '0) ? '0 : gate_cycles - GATE_W'(1);
  assign busy      = (state == GATE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_window = 1'b0;
    window_end  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = GATE;
          load_window = 1'b1;
        end
      end
      GATE: begin
        if (gate_cnt == '0) begin
          window_end = 1'b1;
          if (continuous) load_window = 1'b1;
          else            state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Saturating count; the flag records any edge lost while pinned at full scale.
  always_comb begin
    cnt_next  = edge_cnt;
    flag_next = sat_flag;
    if (state == GATE && rise) begin
      if (edge_cnt == '1) flag_next = 1'b1;
      else                cnt_next  = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat_flag <= 1'b0;
    end else if (load_window) begin
      gate_cnt <= gate_load;
      edge_cnt <= '0;
      sat_flag <= 1'b0;
    end else if (state == GATE) begin
      if (gate_cnt != '0) gate_cnt <= gate_cnt - GATE_W'(1);
      edge_cnt <= cnt_next;
      sat_flag <= flag_next;
    end
  end

  // A window closing in the same cycle as an acceptance wins, keeping result_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else if (window_end) begin
      result       <= cnt_next;
      overflow     <= flag_next;
      result_valid <= 1'b1;
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Self-checking bench for ringosc_freq_meter: table-driven windows, random windows and
// hand-written continuous/handshake/start-while-busy/reset sequences against an edge-count model.
module tb_ringosc_freq_meter;

  localparam int CNT_W  = 24;
  localparam int GATE_W = 16;
  localparam int SYNC   = 2;
  localparam int MAXC   = 60000;

  logic              clk = 1'b0;
  logic              rst;
  logic              osc_in;
  logic              start;
  logic              continuous;
  logic [GATE_W-1:0] gate_cycles;
  logic              result_ready;
  logic              busy, overflow, result_valid;
  logic [CNT_W-1:0]  result;
  logic              busy4, overflow4, valid4;
  logic [3:0]        result4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit samp [MAXC];

  int osc_mode = 0;
  bit osc_lvl  = 1'b0;
  int osc_hp   = 5;
  int osc_cnt  = 0;
  int osc_dur  = 3;

  typedef struct {
    int gate;
    int mode;
    int half;
    bit lvl;
    int lo;
    int hi;
  } vec_t;

  vec_t vecs [7];

  ringosc_freq_meter #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .continuous(continuous),
    .gate_cycles(gate_cycles), .busy(busy), .result(result), .overflow(overflow),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  ringosc_freq_meter #(.CNT_W(4), .GATE_W(GATE_W), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .continuous(continuous),
    .gate_cycles(gate_cycles), .busy(busy4), .result(result4), .overflow(overflow4),
    .result_valid(valid4), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // samp[k] is the osc level captured at clock edge k (zero while reset holds the synchroniser)
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < MAXC) samp[cyc] = rst ? 1'b0 : osc_in;
  end

  always @(negedge clk) begin
    if (osc_mode == 0) begin
      osc_in = osc_lvl;
    end else if (osc_mode == 1) begin
      if (osc_cnt >= osc_hp - 1) begin osc_in = ~osc_in; osc_cnt = 0; end
      else osc_cnt++;
    end else begin
      if (osc_cnt >= osc_dur - 1) begin
        osc_in  = ~osc_in;
        osc_cnt = 0;
        osc_dur = $urandom_range(2, 6);
      end else osc_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Rising edges of the synchronised oscillator visible during clk cycles first..last
  function automatic int rises(input int first, input int last);
    int n = 0;
    for (int c = first; c <= last; c++)
      if (samp[c-SYNC+1] && !samp[c-SYNC]) n++;
    return n;
  endfunction

  function automatic longint satur(input int cnt, input int w);
    longint m = (longint'(1) << w) - 1;
    return (cnt > m) ? m : longint'(cnt);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic applyStimulus(input int g, input bit cont, output int t);
    @(negedge clk);
    gate_cycles = GATE_W'(g);
    continuous  = cont;
    start       = 1'b1;
    t           = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkWindowEnd(input int t, input int n, input int lo, input int hi);
    int cnt;
    waitCycle(t + n);
    checkOutput("busy_last_gate_cycle", 64'(busy), 64'(1));
    waitCycle(t + n + 1);
    cnt = rises(t + 1, t + n);
    checkOutput("busy_after_window", 64'(busy), 64'(0));
    checkOutput("result_valid", 64'(result_valid), 64'(1));
    checkOutput("result", 64'(result), 64'(satur(cnt, CNT_W)));
    checkOutput("overflow", 64'(overflow), 64'(cnt > satur(cnt, CNT_W)));
    checkOutput("result_w4", 64'(result4), 64'(satur(cnt, 4)));
    checkOutput("overflow_w4", 64'(overflow4), 64'(cnt > 15));
    if (hi >= 0) begin
      checks++;
      if (int'(result) < lo || int'(result) > hi) begin
        failures++;
        $display("[TB] FAIL result_range: got %0d expected %0d..%0d", result, lo, hi);
      end
    end
  endtask

  task automatic acceptResult();
    @(negedge clk);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput("valid_drop_after_ready", 64'(result_valid), 64'(0));
  endtask

  task automatic setOsc(input int mode, input int half, input bit lvl);
    @(negedge clk);
    osc_mode = mode;
    osc_hp   = half;
    osc_lvl  = lvl;
    osc_cnt  = 0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int t, n;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; gate_cycles = '0; result_ready = 1'b0;
    osc_in = 1'b0;
    vecs[0] = '{gate: 100, mode: 1, half: 5, lvl: 1'b0, lo: 9,  hi: 11};
    vecs[1] = '{gate: 0,   mode: 0, half: 1, lvl: 1'b1, lo: 0,  hi: 0};
    vecs[2] = '{gate: 100, mode: 1, half: 2, lvl: 1'b0, lo: 24, hi: 26};
    vecs[3] = '{gate: 1,   mode: 0, half: 1, lvl: 1'b0, lo: 0,  hi: 0};
    vecs[4] = '{gate: 37,  mode: 1, half: 3, lvl: 1'b0, lo: 5,  hi: 7};
    vecs[5] = '{gate: 50,  mode: 2, half: 1, lvl: 1'b0, lo: 0,  hi: 50};
    vecs[6] = '{gate: 3,   mode: 1, half: 2, lvl: 1'b0, lo: 0,  hi: 2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_valid", 64'(result_valid), 64'(0));
    checkOutput("reset_result", 64'(result), 64'(0));
    checkOutput("reset_overflow", 64'(overflow), 64'(0));

    for (int i = 0; i < 7; i++) begin
      setOsc(vecs[i].mode, vecs[i].half, vecs[i].lvl);
      applyStimulus(vecs[i].gate, 1'b0, t);
      n = (vecs[i].gate == 0) ? 1 : vecs[i].gate;
      checkOutput("busy_first_gate_cycle", 64'(busy), 64'(1));
      checkWindowEnd(t, n, vecs[i].lo, vecs[i].hi);
      acceptResult();
    end

    setOsc(2, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      int g;
      g = $urandom_range(0, 60);
      applyStimulus(g, 1'b0, t);
      checkWindowEnd(t, (g == 0) ? 1 : g, 0, -1);
      acceptResult();
    end

    // Back-to-back windows: acceptance mid-window, acceptance colliding with a window end,
    // then continuous dropped mid-window so the fourth window is the last
    applyStimulus(20, 1'b1, t);
    for (int k = 0; k < 4; k++) begin
      int e;
      e = t + 20 * (k + 1);
      if (k == 1) begin
        waitCycle(e - 10);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        checkOutput("cont_valid_drop", 64'(result_valid), 64'(0));
      end
      if (k == 3) begin
        waitCycle(e - 5);
        continuous = 1'b0;
      end
      waitCycle(e);
      if (k == 2) result_ready = 1'b1;
      waitCycle(e + 1);
      result_ready = 1'b0;
      checkOutput("cont_busy", 64'(busy), 64'(k < 3));
      checkOutput("cont_valid", 64'(result_valid), 64'(1));
      checkOutput("cont_result", 64'(result), 64'(rises(e - 19, e)));
    end
    acceptResult();

    // start while busy is ignored, and a gate_cycles change mid-window does not shorten it
    setOsc(1, 3, 1'b0);
    applyStimulus(40, 1'b0, t);
    waitCycle(t + 20);
    start = 1'b1;
    gate_cycles = GATE_W'(5);
    @(negedge clk);
    start = 1'b0;
    checkWindowEnd(t, 40, 5, 8);
    repeat (5) @(negedge clk);
    checkOutput("no_second_window", 64'(busy), 64'(0));

    // Reset mid-window with an unconsumed result pending
    setOsc(1, 5, 1'b0);
    applyStimulus(100, 1'b0, t);
    waitCycle(t + 50);
    checkOutput("pre_reset_busy", 64'(busy), 64'(1));
    checkOutput("pre_reset_valid", 64'(result_valid), 64'(1));
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_valid", 64'(result_valid), 64'(0));
    checkOutput("rst_result", 64'(result), 64'(0));
    checkOutput("rst_overflow", 64'(overflow), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_valid", 64'(result_valid), 64'(0));
    checkOutput("post_reset_busy", 64'(busy), 64'(0));
    applyStimulus(100, 1'b0, t);
    checkWindowEnd(t, 100, 9, 11);
    acceptResult();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
